// File: rtl/uart_tx_char_fifo.sv
// First-word-fall-through character FIFO between the string generator and uart_tx_ctl.
// Optional sticky overflow/underflow flags are enabled by defining CHAR_FIFO_ERR_FLAGS_EN.
module uart_tx_char_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic              i_clk_tx,
  input  logic              i_rst_clk_tx,
  input  logic              i_wr_en,
  input  logic [7:0]        i_din,
  output logic              o_full,
  output logic              o_almost_full,
  input  logic              i_rd_en,
  output logic [7:0]        o_dout,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [ADDR_W:0] CntDepth = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntAfull = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CntZero  = '0;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_d, w_rd_ptr_d;
  logic [ADDR_W:0]   r_count, w_count_d;
  logic [7:0]        r_dout, w_dout_d;
  logic              r_empty, r_full, r_afull;
  logic              w_wr_acc, w_rd_acc;

  always_comb begin
    w_rd_acc   = i_rd_en && !r_empty;
    // A pop on a full FIFO frees the slot the simultaneous write lands in.
    w_wr_acc   = i_wr_en && (!r_full || i_rd_en);
    w_wr_ptr_d = w_wr_acc ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
    w_rd_ptr_d = w_rd_acc ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_d = r_count + CntOne;
      2'b01:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase

    // Next head is the incoming byte when it lands in the slot about to be presented.
    w_dout_d = r_dout;
    if (w_count_d != CntZero) begin
      if (w_wr_acc && (r_wr_ptr == w_rd_ptr_d)) begin
        w_dout_d = i_din;
      end else begin
        w_dout_d = r_mem[w_rd_ptr_d];
      end
    end
  end

  always_ff @(posedge i_clk_tx) begin
    if (w_wr_acc && !i_rst_clk_tx) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk_tx) begin
    if (i_rst_clk_tx) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= 8'h00;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      r_dout   <= w_dout_d;
      r_empty  <= (w_count_d == CntZero);
      r_full   <= (w_count_d == CntDepth);
      r_afull  <= (w_count_d >= CntAfull);
    end
  end

`ifdef CHAR_FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  // Only requests that are actually dropped count as errors.
  always_ff @(posedge i_clk_tx) begin
    if (i_rst_clk_tx) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_wr_en && r_full && !i_rd_en) r_overflow <= 1'b1;
      if (i_rd_en && r_empty && !i_wr_en) r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_full        = r_full;
  assign o_almost_full = r_afull;
  assign o_dout        = r_dout;
  assign o_empty       = r_empty;
  assign o_count       = r_count;

endmodule

// File: tb/tb_uart_tx_char_fifo.sv
// Scoreboard bench for uart_tx_char_fifo: a queue model of contents, count and flags
// is stepped alongside the DUT and compared every cycle.
module tb_uart_tx_char_fifo;

  logic       clk;
  logic       i_rst;
  logic       i_wr_en;
  logic [7:0] i_din;
  logic       i_rd_en;
  logic       o_full;
  logic       o_almost_full;
  logic [7:0] o_dout;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_underflow;

  uart_tx_char_fifo #(
    .DEPTH       (16),
    .ADDR_W      (4),
    .AFULL_THRESH(12)
  ) dut (
    .i_clk_tx     (clk),
    .i_rst_clk_tx (i_rst),
    .i_wr_en      (i_wr_en),
    .i_din        (i_din),
    .o_full       (o_full),
    .o_almost_full(o_almost_full),
    .i_rd_en      (i_rd_en),
    .o_dout       (o_dout),
    .o_empty      (o_empty),
    .o_count      (o_count),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q[$];
  int         m_cnt    = 0;
  logic [7:0] m_dout   = 8'h00;
  logic       m_ovf    = 1'b0;
  logic       m_udf    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".count"}, 32'(o_count), 32'(m_cnt));
    check_eq({tag, ".empty"}, 32'(o_empty), 32'(m_cnt == 0));
    check_eq({tag, ".full"},  32'(o_full),  32'(m_cnt == 16));
    check_eq({tag, ".afull"}, 32'(o_almost_full), 32'(m_cnt >= 12));
    check_eq({tag, ".dout"},  32'(o_dout),  32'(m_dout));
    check_eq({tag, ".ovf"},   32'(o_overflow),  32'(m_ovf));
    check_eq({tag, ".udf"},   32'(o_underflow), 32'(m_udf));
  endtask

  // Called at a negedge; drives one cycle of requests, updates the model at the edge.
  task automatic step(input string tag, input logic wr, input logic [7:0] d, input logic rd);
    logic wr_acc, rd_acc;
    i_wr_en = wr;
    i_din   = d;
    i_rd_en = rd;
    @(posedge clk);
    rd_acc = rd && (m_cnt > 0);
    wr_acc = wr && ((m_cnt < 16) || rd);
`ifdef CHAR_FIFO_ERR_FLAGS_EN
    if (wr && m_cnt == 16 && !rd) m_ovf = 1'b1;
    if (rd && m_cnt == 0 && !wr) m_udf = 1'b1;
`endif
    if (rd_acc) void'(q.pop_front());
    if (wr_acc) q.push_back(d);
    m_cnt = q.size();
    if (m_cnt > 0) m_dout = q[0];
    @(negedge clk);
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    check_state(tag);
  endtask

  // Requests held high during reset must be ignored.
  task automatic do_reset();
    i_rst   = 1'b1;
    i_wr_en = 1'b1;
    i_din   = 8'h99;
    i_rd_en = 1'b1;
    @(posedge clk);
    q.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    @(negedge clk);
    i_rst   = 1'b0;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    check_state("reset");
  endtask

  initial begin
    i_rst   = 1'b1;
    i_wr_en = 1'b0;
    i_din   = 8'h00;
    i_rd_en = 1'b0;
    @(negedge clk);
    do_reset();

    // Single write into empty FIFO appears on the next edge.
    step("t1_wr41", 1'b1, 8'h41, 1'b0);
    check_eq("t1_dout41", 32'(o_dout), 32'h41);
    step("t1_pop", 1'b0, 8'h00, 1'b1);
    step("t1_udf", 1'b0, 8'h00, 1'b1);

    // Fill, overfill, drain.
    do_reset();
    for (int i = 0; i < 16; i++) step("t2_fill", 1'b1, 8'(i), 1'b0);
    step("t2_ovf", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check_eq("t2_order", 32'(o_dout), 32'(i));
      step("t2_drain", 1'b0, 8'h00, 1'b1);
    end
    check_eq("t2_empty", 32'(o_empty), 32'd1);

    // Simultaneous read/write while full.
    for (int i = 0; i < 16; i++) step("t3_fill", 1'b1, 8'(8'h20 + i), 1'b0);
    step("t3_rw", 1'b1, 8'hAA, 1'b1);
    check_eq("t3_full", 32'(o_full), 32'd1);
    for (int i = 0; i < 15; i++) step("t3_drain", 1'b0, 8'h00, 1'b1);
    check_eq("t3_aa16th", 32'(o_dout), 32'hAA);
    step("t3_last", 1'b0, 8'h00, 1'b1);

    // Simultaneous read/write while empty.
    step("t4_rw", 1'b1, 8'h55, 1'b1);
    check_eq("t4_dout55", 32'(o_dout), 32'h55);
    check_eq("t4_udf", 32'(o_underflow), 32'd0);
    step("t4_rw1", 1'b1, 8'h66, 1'b1);
    check_eq("t4_dout66", 32'(o_dout), 32'h66);
    step("t4_pop", 1'b0, 8'h00, 1'b1);

    // Random interleaving across many pointer wraps.
    for (int i = 0; i < 300; i++) begin
      step("t5_rand", ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50));
    end

    // Mid-operation reset, then reuse.
    do_reset();
    for (int i = 0; i < 7; i++) step("t6_fill", 1'b1, 8'(8'h70 + i), 1'b0);
    check_eq("t6_cnt7", 32'(o_count), 32'd7);
    do_reset();
    step("t6_wr", 1'b1, 8'hC3, 1'b0);
    check_eq("t6_doutC3", 32'(o_dout), 32'hC3);
    step("t6_pop", 1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
